seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
Parametrised seven-segment display scan controller, replacing the fixed 8-digit anode ring counter.
- Time-multiplexes NUM_DIGITS common-anode digits from one clock.
- Adds a programmable per-digit dwell time, anti-ghosting blank interval, a per-digit enable mask that skips blanked digits, and segment-data muxing.
- Sits between the decoder's character-to-segment logic and the board display pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16).
SCAN_DIV, 10000, clk_10Mhz cycles per digit slot (1 kHz/digit); must be greater than BLANK_CYCLES.
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes and segments off (at least 1).
ACTIVE_LOW, 1, 1 = an_sel and seg_out driven active-low; 0 = active-high.

Ports:
clk_10Mhz  input  1  system clock, 10 MHz.
reset_n  input  1  asynchronous, active-low reset.
enable  input  1  scan enable; low forces display dark.
digit_en  input  NUM_DIGITS  per-digit enable mask; bit i=1 means digit i is scanned.
seg_data  input  NUM_DIGITS*8  logical segment data, active-high; digit i = bits [8i+7:8i] = {dp,g,f,e,d,c,b,a}.
an_sel  output  NUM_DIGITS  anode selects, polarity per ACTIVE_LOW.
seg_out  output  8  cathode segments for the active digit, polarity per ACTIVE_LOW.
digit_idx  output  $clog2(NUM_DIGITS)  index of the digit currently selected.
frame_start  output  1  one-cycle pulse when the lowest-index enabled digit enters ON.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, cnt=0, digit_idx=0, an_sel and seg_out all inactive (all 1s when ACTIVE_LOW=1), frame_start=0.
- All outputs are registered and loaded from next-state logic, so they change on the same edge that the state changes.
- States: IDLE, BLANK, ON. Slot counter cnt is $clog2(SCAN_DIV) bits wide. ON_CYCLES = SCAN_DIV - BLANK_CYCLES.
- go = enable && (digit_en != 0), evaluated every cycle in every state.
- IDLE:
  - If go, move to BLANK with digit_idx = lowest set bit of digit_en and cnt=0.
  - Otherwise stay in IDLE.
- BLANK:
  - Anodes and segments inactive; cnt increments.
  - At cnt == BLANK_CYCLES-1, move to ON with cnt=0.
- ON:
  - Only an_sel[digit_idx] is active.
  - seg_out = polarity(seg_data[digit_idx]), re-sampled every cycle, so a seg_data change appears 1 cycle later.
  - At cnt == ON_CYCLES-1, digit_idx moves to the next set bit of digit_en strictly above the current index, wrapping to 0. If no other bit is set, digit_idx is unchanged. Then move to BLANK with cnt=0.
- Mid-slot enable drop: if digit_en[digit_idx] deasserts during ON, the slot ends early. Advance as above and enter BLANK on the next edge.
- go low in any state: next edge enters IDLE with all outputs inactive. Restart always begins with BLANK at the lowest enabled digit.
- A single enabled digit still gets the BLANK interval every slot, so duty cycle and brightness are independent of the number of enabled digits.
- frame_start: asserted for exactly one cycle on the edge entering ON when digit_idx equals the lowest set bit of digit_en.
- Changes to digit_en while in BLANK take effect at the next advance. The current index completes its BLANK and then goes to ON only if its enable bit is still set; otherwise it advances immediately.
- Exactly one anode is ever active, and none is active in BLANK or IDLE.

Decomposition:
- seg_scan_pkg holds:
  - the state enum scan_state_t {IDLE, BLANK, ON};
  - constant SEG_BITS=8;
  - a function for the ACTIVE_LOW polarity apply.
- One combinational sub-module, scan_next_digit:
  - inputs: digit_en and current index;
  - outputs: next enabled index (rotating priority search, strictly-above with wrap) and lowest set index.

Test Plan:
1. NUM_DIGITS=8, SCAN_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1, enable=1, digit_en=8'hFF, reset release -> an_sel=8'hFF for 2 cycles, then 8'hFE for 6 cycles, 8'hFF for 2 cycles, 8'hFD for 6 cycles. frame_start pulses once every 64 cycles at entry of digit 0 ON.
2. digit_en=8'b1010_0001 -> ON order is digits 0, 5, 7, 0. Each slot is 8 cycles; skipped digits never go low.
3. digit_en=8'h10 -> digit_idx stays 4. an_sel alternates 8'hFF (2 cycles) and 8'hEF (6 cycles). frame_start pulses every 8 cycles.
4. During ON of digit 2, clear digit_en[2] -> next edge an_sel=8'hFF (BLANK), then digit 3 ON. Separately, drop enable -> next edge IDLE with an_sel=8'hFF and seg_out=8'hFF.
5. With seg_data digit 0 = 8'h3F, ACTIVE_LOW=1 -> seg_out=8'hC0 during digit 0 ON. Change seg_data mid-ON to 8'h06 -> seg_out=8'hF9 exactly 1 cycle later.
6. Assert reset_n low asynchronously between clock edges mid-ON -> an_sel, seg_out and digit_idx return to reset values immediately, without waiting for a clock edge. After release, the scan restarts with BLANK at the lowest enabled digit.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg_scan_pkg;

  localparam int unsigned SEG_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } scan_state_t;

  function automatic logic [SEG_BITS-1:0] apply_polarity(input logic [SEG_BITS-1:0] value,
                                                         input logic                active_low);
    return active_low ? ~value : value;
  endfunction

endpackage

// File: rtl/scan_next_digit.sv
// Rotating priority search over the digit enable mask: next enabled index strictly above
// the current one (wrapping), plus the lowest enabled index.
module scan_next_digit #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [IDX_W-1:0]      cur_idx,
  output logic [IDX_W-1:0]      next_idx,
  output logic [IDX_W-1:0]      low_idx
);

  logic found;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (digit_en[i]) low_idx = IDX_W'(i);
    end
  end

  // Falls back to cur_idx when no other digit is enabled.
  always_comb begin
    next_idx = cur_idx;
    found    = 1'b0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      int cand;
      cand = (int'(cur_idx) + k) % NUM_DIGITS;
      if (!found && digit_en[cand]) begin
        next_idx = IDX_W'(cand);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: per-digit dwell with leading blank interval, enable mask
// skipping, segment muxing and selectable output polarity. All outputs are registered.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 10000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                            clk_10Mhz,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic [NUM_DIGITS-1:0]           digit_en,
  input  logic [NUM_DIGITS*SEG_BITS-1:0]  seg_data,
  output logic [NUM_DIGITS-1:0]           an_sel,
  output logic [SEG_BITS-1:0]             seg_out,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
  output logic                            frame_start
);

  localparam int unsigned IDX_W     = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W     = $clog2(SCAN_DIV);
  localparam int unsigned ON_CYCLES = SCAN_DIV - BLANK_CYCLES;

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [SEG_BITS-1:0]   SEG_OFF = {SEG_BITS{ACTIVE_LOW}};

  scan_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_d;
  logic [IDX_W-1:0]      next_idx, low_idx;
  logic [NUM_DIGITS-1:0] an_d, onehot;
  logic [SEG_BITS-1:0]   seg_d;
  logic                  fs_d;
  logic                  go;

  assign go = enable && (digit_en != '0);

  scan_next_digit #(
    .NUM_DIGITS (NUM_DIGITS),
    .IDX_W      (IDX_W)
  ) u_next (
    .digit_en (digit_en),
    .cur_idx  (digit_idx),
    .next_idx (next_idx),
    .low_idx  (low_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = digit_idx;
    fs_d    = 1'b0;
    if (!go) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = low_idx;
        end
        BLANK: begin
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            cnt_d = '0;
            // A digit disabled during its blank interval is skipped; the next one blanks first.
            if (digit_en[digit_idx]) begin
              state_d = ON;
              fs_d    = (digit_idx == low_idx);
            end else begin
              idx_d = next_idx;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ON: begin
          if ((cnt_q == CNT_W'(ON_CYCLES - 1)) || !digit_en[digit_idx]) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = next_idx;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Outputs are derived from next state so they switch on the same edge as the FSM.
  always_comb begin
    onehot = NUM_DIGITS'(1) << idx_d;
    an_d   = AN_OFF;
    seg_d  = SEG_OFF;
    if (state_d == ON) begin
      an_d  = ACTIVE_LOW ? ~onehot : onehot;
      seg_d = apply_polarity(seg_data[SEG_BITS*int'(idx_d) +: SEG_BITS], ACTIVE_LOW);
    end
  end

  always_ff @(posedge clk_10Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      digit_idx   <= '0;
      an_sel      <= AN_OFF;
      seg_out     <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      digit_idx   <= idx_d;
      an_sel      <= an_d;
      seg_out     <= seg_d;
      frame_start <= fs_d;
    end
  end

endmodule
